seven_seg_scan: RTL
===================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of hex digits displayed (range 1-8).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 50000, giving the clk cycles each digit is driven per scan slot (minimum 2).
REQ-003 The module SHALL have parameter DEAD_CYCLES, default 16, giving the clk cycles all anodes are off between slots (minimum 1).
REQ-004 The module SHALL have parameter BLINK_FRAMES, default 64, giving the frames per blink half-period (minimum 1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 data_in  input  4*NUM_DIGITS  hex value; nibble k drives digit k, nibble 0 least significant.
REQ-008 dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-009 load  input  1  strobe; captures data_in and dp_in into the shadow register.
REQ-010 blank_lz  input  1  1 = blank leading zero digits.
REQ-011 blink_en  input  1  1 = whole display blinks.
REQ-012 seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-013 dp  output  1  active-low decimal point.
REQ-014 an  output  NUM_DIGITS  active-low digit enables, at most one low at any time.
REQ-015 frame_start  output  1  one-cycle pulse on entry to slot of digit 0.

Function
REQ-016 Glyphs SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, with the leftmost bit driving seg[0] (a) and the rightmost driving seg[6] (g).
REQ-017 The scanner SHALL be a two-state FSM, ON and DEAD, with a cycle counter and a digit index idx.
REQ-018 ON SHALL last exactly REFRESH_DIV cycles with an[idx]=0 and seg/dp showing digit idx; it then enters DEAD.
REQ-019 DEAD SHALL last exactly DEAD_CYCLES cycles with an all 1s, seg=7'b1111111 and dp=1.
REQ-020 On DEAD->ON the FSM SHALL increment idx, wrapping from NUM_DIGITS-1 to 0; a full frame is NUM_DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
REQ-021 seg, dp and an SHALL be registered and change on the same edge as the FSM state.
REQ-022 load=1 SHALL copy data_in/dp_in into the shadow register at that edge.
REQ-023 The display register SHALL copy the shadow register on the DEAD->ON edge where idx wraps to 0, so a frame never shows mixed values.
REQ-024 If load coincides with that edge, the display SHALL take the pre-load shadow value, and the new value SHALL appear from the next frame.
REQ-025 frame_start SHALL be 1 for exactly the first ON cycle of digit 0 and 0 otherwise.
REQ-026 With blank_lz=1, digit k>0 SHALL be blanked (an[k] stays 1 during its slot) when display nibbles k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-027 A blanked digit SHALL still consume its full ON slot time.
REQ-028 A blink phase bit SHALL toggle every BLINK_FRAMES frame_start pulses.
REQ-029 While blink_en=1 and phase=1, all anodes SHALL stay 1 throughout the frame.
REQ-030 The blink frame counter SHALL run regardless of blink_en.
REQ-031 An asserted dp_in bit in the display register SHALL drive dp=0 during that digit's unblanked ON slot.

Reset
REQ-032 With rst_n=0 at a clk edge, the block SHALL set: state=DEAD, counter=0, idx=NUM_DIGITS-1, an all 1s, seg=7'b1111111, dp=1, frame_start=0.
REQ-033 Reset SHALL also clear the shadow register, display register, blink counter and phase to 0.
REQ-034 Reset asserted mid-slot SHALL take effect at the next edge with no partial slot completed.
REQ-035 After release, the first ON slot SHALL be digit 0 after DEAD_CYCLES cycles, with frame_start pulsed.

Verification
REQ-036 Use NUM_DIGITS=3, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2 for scenarios unless stated.
REQ-037 Scan order: reset, load 12'h1A5 -> an sequence 110x4, 111, 101x4, 111, 011x4, 111; digit 0 seg=0100100; frame=15 cycles; display updates at second frame_start.
REQ-038 Leading-zero blank: load 12'h007 with blank_lz=1 -> only digit 0 lit (seg=0001111); digits 1 and 2 dark for 4 cycles each; blank_lz=0 -> digits 1 and 2 show 0000001.
REQ-039 Tear-free update: pulse load with 12'h222 mid-frame, then 12'h333 on the wrap edge -> one full frame of 222, then 333, and no frame mixing values.
REQ-040 Blink: blink_en=1 -> 2 frames lit, 2 frames all anodes 1, repeating; dp_in=3'b010 -> dp=0 only in digit 1 lit slots.
REQ-041 Reset mid-ON slot of digit 1 -> next edge: an=111, seg=1111111; first lit slot is digit 0 after 1 cycle, showing 000 (display cleared).

Source files
------------

// File: rtl/seven_seg_scan.sv
// Multiplexed hex seven-segment scanner.
// The scan cycles through ON and DEAD slots, one ON slot per digit.
// Data is captured into a shadow register on load and moved to the display
// register only when a frame starts, so a frame never mixes two values.
// It also supports leading-zero blanking and whole-display blinking.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW   = $clog2(BLINK_FRAMES) + 1;

  localparam logic [0:0] ST_DEAD = 1'b0;
  localparam logic [0:0] ST_ON   = 1'b1;

  logic [0:0]                  state, nxt_state;
  logic [CW-1:0]               cnt, nxt_cnt;
  logic [IW-1:0]               idx, nxt_idx;
  logic                        wrap;
  logic [NUM_DIGITS-1:0][3:0]  shadow_d, disp_d, nxt_disp_d;
  logic [NUM_DIGITS-1:0]       shadow_p, disp_p, nxt_disp_p;
  logic [BW-1:0]               blink_cnt;
  logic                        phase, frame_dark, nxt_dark;
  logic [NUM_DIGITS-1:0]       upper_zero;
  logic                        lit, acc;
  logic [3:0]                  nib;
  logic [6:0]                  seg_n;
  logic                        dp_n;
  logic [NUM_DIGITS-1:0]       an_n;

  // Segment pattern for a nibble, bit order {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Next scan state: slot timing, digit advance and frame wrap detection.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CW'(1);
    nxt_idx   = idx;
    wrap      = 1'b0;
    if (state == ST_ON) begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        nxt_state = ST_DEAD;
        nxt_cnt   = '0;
      end
    end else if (cnt == CW'(DEAD_CYCLES - 1)) begin
      nxt_state = ST_ON;
      nxt_cnt   = '0;
      if (idx == IW'(NUM_DIGITS - 1)) begin
        nxt_idx = '0;
        wrap    = 1'b1;
      end else begin
        nxt_idx = idx + IW'(1);
      end
    end
  end

  // Output values for the upcoming cycle, so outputs move with the state.
  always_comb begin
    nxt_disp_d = wrap ? shadow_d : disp_d;
    nxt_disp_p = wrap ? shadow_p : disp_p;
    nxt_dark   = wrap ? (blink_en & phase) : frame_dark;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc           = acc & (nxt_disp_d[k] == 4'd0);
      upper_zero[k] = acc;
    end
    nib   = nxt_disp_d[nxt_idx];
    lit   = (nxt_state == ST_ON) && !nxt_dark &&
            !(blank_lz && (nxt_idx != '0) && upper_zero[nxt_idx]);
    seg_n = lit ? glyph(nib) : 7'b1111111;
    dp_n  = lit ? ~nxt_disp_p[nxt_idx] : 1'b1;
    an_n  = lit ? ~(NUM_DIGITS'(1) << nxt_idx) : '1;
  end

  // Scan FSM, data registers, blink timing and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_DEAD;
      cnt         <= '0;
      idx         <= IW'(NUM_DIGITS - 1);
      shadow_d    <= '0;
      shadow_p    <= '0;
      disp_d      <= '0;
      disp_p      <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      frame_dark  <= 1'b0;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      disp_d      <= nxt_disp_d;
      disp_p      <= nxt_disp_p;
      frame_dark  <= nxt_dark;
      seg         <= seg_n;
      dp          <= dp_n;
      an          <= an_n;
      frame_start <= wrap;
      if (load) begin
        shadow_d <= data_in;
        shadow_p <= dp_in;
      end
      if (wrap) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule
